// File: rtl/uart_pkt_ctrl.sv
// Packet framing controller behind uart_rx. It hunts for SYNC, checks LEN and the XOR checksum, then replays the payload.
// Define UART_PKT_TIMEOUT_EN to add the inter-byte idle timeout.
module uart_pkt_ctrl #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic       pkt_done,
   output logic       len_err,
   output logic       csum_err,
   output logic       overrun_err,
   output logic       timeout_err
);

   localparam int unsigned PW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("uart_pkt_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CHECK, ST_DRAIN} state_t;

   state_t          state;
   logic [7:0]      len;
   logic [7:0]      csum;
   logic [PW-1:0]   wr;
   logic [PW-1:0]   rd;
   logic [PW-1:0]   rd_nxt;
   logic            len_bad;
   logic [7:0]      payload_mem [MAX_LEN];

   assign rd_nxt  = rd + PW'(1);
   assign len_bad = (rx_data == 8'd0) || (32'(rx_data) > MAX_LEN);
   assign busy    = (state != ST_IDLE);

`ifdef UART_PKT_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
   logic          timeout_q;
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         len         <= '0;
         csum        <= '0;
         wr          <= '0;
         rd          <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         pkt_done    <= 1'b0;
         len_err     <= 1'b0;
         csum_err    <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
         idle_cnt    <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         pkt_done    <= 1'b0;
         len_err     <= 1'b0;
         csum_err    <= 1'b0;
         overrun_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid && rx_data == SYNC_BYTE) state <= ST_LEN;
            end
            ST_LEN: begin
               if (rx_valid) begin
                  if (len_bad) begin
                     len_err <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     len   <= rx_data;
                     csum  <= rx_data;
                     wr    <= '0;
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (rx_valid) begin
                  payload_mem[wr[IW-1:0]] <= rx_data;
                  csum <= csum ^ rx_data;
                  wr   <= wr + PW'(1);
                  if (8'(wr) == len - 8'd1) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (rx_valid) begin
                  if (rx_data == csum) begin
                     // Preload the first byte so out_valid and out_data rise together.
                     rd        <= '0;
                     out_valid <= 1'b1;
                     out_data  <= payload_mem[0];
                     out_last  <= (len == 8'd1);
                     state     <= ST_DRAIN;
                  end else begin
                     csum_err <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            ST_DRAIN: begin
               if (rx_valid) overrun_err <= 1'b1;
               if (out_valid && out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     pkt_done  <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     rd       <= rd_nxt;
                     out_data <= payload_mem[rd_nxt[IW-1:0]];
                     out_last <= (8'(rd_nxt) == len - 8'd1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
`ifdef UART_PKT_TIMEOUT_EN
         // Counter is cleared in IDLE/DRAIN so every entry into LEN starts from zero.
         timeout_q <= 1'b0;
         if ((state inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) && !rx_valid) begin
            if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               timeout_q <= 1'b1;
               idle_cnt  <= '0;
               state     <= ST_IDLE;
            end else begin
               idle_cnt <= idle_cnt + TW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Directed bench for uart_pkt_ctrl: expected payload bytes are queued as frames are sent and checked on each output handshake.
module tb_uart_pkt_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       pkt_done;
   logic       len_err;
   logic       csum_err;
   logic       overrun_err;
   logic       timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   int pkt_cnt = 0, len_cnt = 0, csum_cnt = 0, ovr_cnt = 0, to_cnt = 0;
   int cyc = 0;
   logic [8:0] exp_q [$];

   uart_pkt_ctrl #(
      .MAX_LEN        (16),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .pkt_done    (pkt_done),
      .len_err     (len_err),
      .csum_err    (csum_err),
      .overrun_err (overrun_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop and event pulse counting, sampled mid-cycle
   always @(negedge clk) begin
      if (pkt_done)    pkt_cnt++;
      if (len_err)     len_cnt++;
      if (csum_err)    csum_cnt++;
      if (overrun_err) ovr_cnt++;
      if (timeout_err) to_cnt++;
      if (reset && out_valid && out_ready) begin
         check("unexpected_out", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("out_last_data", {23'd0, out_last, out_data}, 32'(exp_q.pop_front()));
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_complete", 32'(exp_q.size()), 32'd0);
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c;
      logic [7:0] b;
      int t0, p0, o0, l0, c0;
      reset = 1'b0; rx_data = '0; rx_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulses", {27'd0, pkt_done, len_err, csum_err, overrun_err, timeout_err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      // 1: basic packet with leading junk byte
      exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
      send(8'h3C); send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      wait_drain();
      check("t1_pkt_done", 32'(pkt_cnt), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);

      // 2: checksum error then a one-byte packet
      send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hFF);
      @(negedge clk);
      check("t2_csum_pulse", 32'(csum_err), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("t2_csum_one_cycle", 32'(csum_err), 32'd0);
      @(posedge clk); #1;
      exp_q.push_back({1'b1, 8'h7E});
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      wait_drain();
      check("t2_counts", {csum_cnt[15:0], pkt_cnt[15:0]}, {16'd1, 16'd2});

      // 3: illegal lengths, then a maximum-length packet
      send(8'hA5); send(8'h00);
      @(negedge clk);
      check("t3_len0_pulse", 32'(len_err), 32'd1);
      check("t3_len0_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      send(8'hA5); send(8'h11);
      @(negedge clk);
      check("t3_len17_pulse", 32'(len_err), 32'd1);
      check("t3_len17_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("t3_len_cnt", 32'(len_cnt), 32'd2);
      c = 8'h10;
      for (int i = 0; i < 16; i++) begin
         b = 8'(i * 7 + 1);
         c ^= b;
         exp_q.push_back({(i == 15), b});
      end
      send(8'hA5); send(8'h10);
      for (int i = 0; i < 16; i++) send(8'(i * 7 + 1));
      send(c);
      wait_drain();
      check("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

      // 4: back-pressure with an overrun byte
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 8'hAA}); exp_q.push_back({1'b0, 8'hBB}); exp_q.push_back({1'b1, 8'hCC});
      send(8'hA5); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDE);
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            send(8'h55);
            @(negedge clk);
            check("t4_overrun_pulse", 32'(overrun_err), 32'd1);
         end else begin
            @(negedge clk);
         end
         check("t4_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'hAA});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain();
      check("t4_counts", {ovr_cnt[15:0], pkt_cnt[15:0]}, {16'd1, 16'd4});

      // 4b: final handshake collides with a SYNC-valued byte
      out_ready = 1'b0;
      exp_q.push_back({1'b1, 8'h44});
      send(8'hA5); send(8'h01); send(8'h44); send(8'h45);
      @(negedge clk);
      check("t4b_valid_last", {30'd0, out_valid, out_last}, 32'd3);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'hA5);
      send(8'h01); send(8'h77); send(8'h76);
      idle(3);
      check("t4b_ovr_cnt", 32'(ovr_cnt), 32'd2);
      check("t4b_pkt_cnt", 32'(pkt_cnt), 32'd5);
      check("t4b_idle", {30'd0, busy, out_valid}, 32'd0);
      check("t4b_queue", 32'(exp_q.size()), 32'd0);

      // 5: inter-byte timeout
      send(8'hA5); send(8'h02); send(8'h10);
      t0 = cyc;
`ifdef UART_PKT_TIMEOUT_EN
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (timeout_err) begin seen = cyc - t0; break; end
         end
         check("t5_timeout_delay", 32'(seen), 32'd100);
         check("t5_busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
         idle(2);
         check("t5_to_cnt", 32'(to_cnt), 32'd1);
      end
`else
      idle(150);
      check("t5_still_busy", 32'(busy), 32'd1);
      check("t5_no_timeout", 32'(to_cnt), 32'd0);
      exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b1, 8'h20});
      send(8'h20); send(8'h32);
      wait_drain();
      check("t5_pkt_cnt", 32'(pkt_cnt), 32'd6);
`endif

      // 6: reset in the middle of a payload
      p0 = pkt_cnt; o0 = ovr_cnt; l0 = len_cnt; c0 = csum_cnt;
      send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
      check("t6_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_rst_outputs", {20'd0, busy, out_valid, out_last, out_data, pkt_done, len_err, csum_err},
            32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(1);
      exp_q.push_back({1'b0, 8'h5A}); exp_q.push_back({1'b1, 8'hA5});
      send(8'hA5); send(8'h02); send(8'h5A); send(8'hA5); send(8'hFD);
      wait_drain();
      check("t6_pkt_cnt", 32'(pkt_cnt), 32'(p0 + 1));
      check("t6_no_errs", {ovr_cnt[7:0], len_cnt[7:0], csum_cnt[7:0], 8'd0},
            {o0[7:0], l0[7:0], c0[7:0], 8'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
